// File: rtl/xip_flash_pkg.sv
// rtl/xip_flash_pkg.sv - shared constants and types for the XIP flash responder
package xip_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;

  localparam int SPI_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - 2-flop synchronizer with registered rise/fall pulses
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input pin
//   q        : synchronized level (2 clk after pin)
//   rise     : one-cycle pulse, 3 clk after a pin rising edge
//   fall     : one-cycle pulse, 3 clk after a pin falling edge
module spi_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  // All flops reset low. For chip select this means a csn pin that is
  // already low when reset releases produces no fall pulse, so an
  // interrupted transaction is never resumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
      q_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      q    <= meta;
      q_d  <= q;
      rise <= q & ~q_d;
      fall <= ~q & q_d;
    end
  end

endmodule

// File: rtl/xip_flash_responder.sv
// rtl/xip_flash_responder.sv - SPI NOR-flash responder serving READ (0x03) and READ-ID (0x9F)
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   xip_csn/clk/sdo  : SPI pins from the master (async, mode 0)
//   xip_sdi          : SPI data to the master
//   mem_req/mem_addr : one-cycle read strobe and address to byte memory
//   mem_rdata        : read data, valid one clk after mem_req
//   busy             : a transaction is selected (FSM not idle)
module xip_flash_responder
  import xip_flash_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xip_csn,
  input  logic              xip_clk,
  input  logic              xip_sdo,
  output logic              xip_sdi,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  // Shift register only needs the low ADDR_W address bits (the last ones
  // shifted in); earlier address bits fall off the top. Needs >= 7 for
  // opcode decode.
  localparam int SH_W = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;

  localparam logic [4:0]        CMD_LAST  = 5'd7;
  localparam logic [4:0]        ADDR_LAST = 5'(SPI_ADDR_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic csn_q, csn_rise, csn_fall;
  logic sdo_q, sdo_rise, sdo_fall;
  logic unused_sync;

  spi_in_sync u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (xip_clk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_in_sync u_csn_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (xip_csn),
    .q    (csn_q),
    .rise (csn_rise),
    .fall (csn_fall)
  );

  spi_in_sync u_sdo_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (xip_sdo),
    .q    (sdo_q),
    .rise (sdo_rise),
    .fall (sdo_fall)
  );

  assign unused_sync = ^{sclk_q, csn_rise, sdo_rise, sdo_fall};

  state_t            state, nxt_state;
  logic [4:0]        bit_cnt, nxt_bit_cnt;
  logic [SH_W-1:0]   shift_in, nxt_shift_in;
  logic [ADDR_W-1:0] addr, nxt_addr;
  logic [7:0]        out_shift, nxt_out_shift;
  logic [1:0]        id_idx, nxt_id_idx;
  logic              nxt_sdi;
  logic              nxt_mem_req;
  logic [ADDR_W-1:0] nxt_mem_addr;
  logic [7:0]        prefetch;
  logic              mem_req_d;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] rx_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]        id_byte;

  assign opcode   = {shift_in[6:0], sdo_q};
  assign rx_addr  = {shift_in[ADDR_W-2:0], sdo_q};
  assign addr_inc = addr + ADDR_ONE;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    id_byte = 8'h00;
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  // Sync csn level lands one cycle before any sclk edge pulse taken at the
  // same pin instant, so csn always wins a simultaneous edge.
  always_comb begin
    nxt_state     = state;
    nxt_bit_cnt   = bit_cnt;
    nxt_shift_in  = shift_in;
    nxt_addr      = addr;
    nxt_out_shift = out_shift;
    nxt_id_idx    = id_idx;
    nxt_sdi       = xip_sdi;
    nxt_mem_req   = 1'b0;
    nxt_mem_addr  = mem_addr;

    if (csn_q) begin
      nxt_state   = ST_IDLE;
      nxt_bit_cnt = '0;
      nxt_sdi     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (csn_fall) begin
            nxt_state    = ST_CMD;
            nxt_bit_cnt  = '0;
            nxt_shift_in = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            nxt_shift_in = {shift_in[SH_W-2:0], sdo_q};
            nxt_bit_cnt  = bit_cnt + 5'd1;
            if (bit_cnt == CMD_LAST) begin
              nxt_bit_cnt = '0;
              case (opcode)
                OP_READ: nxt_state = ST_ADDR;
                OP_RDID: begin
                  nxt_state  = ST_ID;
                  nxt_id_idx = '0;
                end
                default: nxt_state = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            nxt_shift_in = {shift_in[SH_W-2:0], sdo_q};
            nxt_bit_cnt  = bit_cnt + 5'd1;
            if (bit_cnt == ADDR_LAST) begin
              nxt_bit_cnt  = '0;
              nxt_addr     = rx_addr;
              nxt_mem_req  = 1'b1;
              nxt_mem_addr = rx_addr;
              nxt_state    = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Byte boundary: hand the prefetched byte to the shifter and
          // immediately fetch the following one.
          if (sclk_fall) begin
            nxt_bit_cnt = bit_cnt + 5'd1;
            if (bit_cnt[2:0] == 3'd0) begin
              nxt_out_shift = prefetch;
              nxt_sdi       = prefetch[7];
              nxt_addr      = addr_inc;
              nxt_mem_req   = 1'b1;
              nxt_mem_addr  = addr_inc;
            end else begin
              nxt_out_shift = {out_shift[6:0], 1'b0};
              nxt_sdi       = out_shift[6];
            end
          end
        end
        ST_ID: begin
          if (sclk_fall) begin
            nxt_bit_cnt = bit_cnt + 5'd1;
            if (bit_cnt[2:0] == 3'd0) begin
              nxt_out_shift = id_byte;
              nxt_sdi       = id_byte[7];
              nxt_id_idx    = (id_idx == 2'd3) ? id_idx : id_idx + 2'd1;
            end else begin
              nxt_out_shift = {out_shift[6:0], 1'b0};
              nxt_sdi       = out_shift[6];
            end
          end
        end
        ST_IGNORE: begin
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      addr      <= '0;
      out_shift <= '0;
      id_idx    <= '0;
      xip_sdi   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= nxt_state;
      bit_cnt   <= nxt_bit_cnt;
      shift_in  <= nxt_shift_in;
      addr      <= nxt_addr;
      out_shift <= nxt_out_shift;
      id_idx    <= nxt_id_idx;
      xip_sdi   <= nxt_sdi;
      mem_req   <= nxt_mem_req;
      mem_addr  <= nxt_mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_d <= 1'b0;
      prefetch  <= '0;
    end else begin
      mem_req_d <= mem_req;
      if (mem_req_d) begin
        prefetch <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_xip_flash_responder.sv
// tb/tb_xip_flash_responder.sv - self-checking bench for xip_flash_responder
module tb_xip_flash_responder;
  import xip_flash_pkg::*;

  localparam int ADDR_W = 16;
  localparam int H      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              xip_csn;
  logic              xip_clk;
  logic              xip_sdo;
  logic              xip_sdi;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              busy;

  logic [7:0]        mem [0:65535];
  logic [7:0]        exp_data[$];
  logic [ADDR_W-1:0] exp_req[$];
  int                errors = 0;
  int                checks = 0;

  typedef struct {
    logic [7:0]        op;
    logic [23:0]       addr;
    int                nbytes;
    logic [39:0]       exp_bytes;
    logic [ADDR_W-1:0] req_base;
    int                n_req;
  } vec_t;

  vec_t vecs[5];

  xip_flash_responder #(
    .ADDR_W   (ADDR_W),
    .JEDEC_ID (24'hEF4018)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .xip_csn   (xip_csn),
    .xip_clk   (xip_clk),
    .xip_sdo   (xip_sdo),
    .xip_sdi   (xip_sdi),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data only valid the cycle after a request.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? mem[mem_addr] : 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_req) begin
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_req_unexpected: got addr 0x%0h expected no request", mem_addr);
      end else begin
        check("mem_req_addr", 32'(mem_addr), 32'(exp_req.pop_front()));
      end
    end
  end

  task automatic check_data(input string tag, input logic [7:0] rx);
    if (exp_data.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_data_extra: got 0x%0h expected none", tag, rx);
    end else begin
      check({tag, "_data"}, 32'(rx), 32'(exp_data.pop_front()));
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic last,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      xip_sdo = tx[i];
      repeat (H) @(negedge clk);
      xip_clk = 1'b1;
      rx = {rx[6:0], xip_sdi};
      repeat (H) @(negedge clk);
      xip_clk = 1'b0;
      // csn rising together with the final falling edge: the edge is ignored
      if (last && i == 8 - nbits) xip_csn = 1'b1;
    end
  endtask

  task automatic end_txn(input string tag);
    xip_csn = 1'b1;
    repeat (H) @(negedge clk);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_sdi_end"}, 32'(xip_sdi), 32'd0);
    check({tag, "_req_missing"}, 32'(exp_req.size()), 32'd0);
    exp_req.delete();
    exp_data.delete();
  endtask

  task automatic run_txn(input string tag, input logic [7:0] op, input logic [23:0] addr,
                         input int nbytes, input logic [39:0] exp_bytes,
                         input logic [ADDR_W-1:0] req_base, input int n_req);
    logic [7:0] rx;
    for (int i = 0; i < n_req; i++) exp_req.push_back(req_base + ADDR_W'(i));
    for (int i = 0; i < nbytes; i++) exp_data.push_back(exp_bytes[8*(nbytes-1-i) +: 8]);
    xip_csn = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(op, 8, 1'b0, rx);
    repeat (4) @(negedge clk);
    check({tag, "_busy_cmd"}, 32'(busy), 32'd1);
    if (op == OP_READ) begin
      for (int b = 2; b >= 0; b--) spi_bits(addr[8*b +: 8], 8, 1'b0, rx);
    end
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(8'($urandom), 8, i == nbytes - 1, rx);
      check_data(tag, rx);
    end
    end_txn(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    rst     = 1'b1;
    xip_csn = 1'b1;
    xip_clk = 1'b0;
    xip_sdo = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3);
    mem[16'h0100] = 8'hA5;
    mem[16'h0101] = 8'h5A;
    mem[16'h0102] = 8'h0F;
    mem[16'h0103] = 8'hF0;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'h3C;
    mem[16'h0010] = 8'h96;
    mem[16'h0200] = 8'hB7;
    mem[16'h0300] = 8'h5C;
    mem[16'h0301] = 8'hFF;

    repeat (3) @(negedge clk);
    check("reset_sdi", 32'(xip_sdi), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (H) @(negedge clk);

    vecs[0] = '{op: OP_READ, addr: 24'h000100, nbytes: 4, exp_bytes: 40'h00A55A0FF0,
                req_base: 16'h0100, n_req: 5};
    vecs[1] = '{op: OP_READ, addr: 24'h00FFFF, nbytes: 2, exp_bytes: 40'h000000C33C,
                req_base: 16'hFFFF, n_req: 3};
    vecs[2] = '{op: OP_RDID, addr: 24'h000000, nbytes: 5, exp_bytes: 40'hEF40180000,
                req_base: 16'h0000, n_req: 0};
    vecs[3] = '{op: 8'hAB, addr: 24'h000000, nbytes: 2, exp_bytes: 40'h0000000000,
                req_base: 16'h0000, n_req: 0};
    vecs[4] = '{op: OP_READ, addr: 24'hAB0010, nbytes: 1, exp_bytes: 40'h0000000096,
                req_base: 16'h0010, n_req: 2};

    for (int v = 0; v < 5; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].nbytes,
              vecs[v].exp_bytes, vecs[v].req_base, vecs[v].n_req);
    end

    // Abort after 4 data bits, then a clean READ at 0x10.
    exp_req.push_back(16'h0200);
    exp_req.push_back(16'h0201);
    xip_csn = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(OP_READ, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h02, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h00, 4, 1'b0, rx);
    check("abort_nibble", 32'(rx[3:0]), 32'hB);
    repeat (H) @(negedge clk);
    end_txn("abort");
    run_txn("after_abort", OP_READ, 24'h000010, 1, 40'h96, 16'h0010, 2);

    // Reset in the middle of DATA with csn held low.
    exp_req.push_back(16'h0300);
    exp_req.push_back(16'h0301);
    exp_req.push_back(16'h0302);
    exp_data.push_back(8'h5C);
    xip_csn = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(OP_READ, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h03, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h00, 8, 1'b0, rx);
    check_data("rst_mid", rx);
    spi_bits(8'h00, 3, 1'b0, rx);
    repeat (4) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    check("rst_mid_sdi_before", 32'(xip_sdi), 32'd1);
    check("rst_mid_req_before", 32'(exp_req.size()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_sdi", 32'(xip_sdi), 32'd0);
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    spi_bits(8'hFF, 8, 1'b0, rx);
    check("rst_mid_no_resume", 32'(rx), 32'd0);
    check("rst_mid_busy_idle", 32'(busy), 32'd0);
    end_txn("rst_mid");
    run_txn("after_rst", OP_READ, 24'h000010, 1, 40'h96, 16'h0010, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
